// File: rtl/comms_pkg.sv
// ---------------------------------------------------------------------------
// comms_pkg
//   Shared definitions for the comms TX path: frame marker bytes, source
//   index constants, per-source payload lengths and the TX scheduler state
//   encoding.
// ---------------------------------------------------------------------------
package comms_pkg;

    // Frame framing bytes
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] SRC_TAG_BASE = 8'h10;

    // Source indices (fixed priority, index 0 highest)
    localparam logic [1:0] SRC_GRID   = 2'd0;
    localparam logic [1:0] SRC_PLAYER = 2'd1;
    localparam logic [1:0] SRC_INFO   = 2'd2;

    // Nominal payload length produced by each source
    localparam logic [7:0] LEN_GRID   = 8'd54;
    localparam logic [7:0] LEN_PLAYER = 8'd3;
    localparam logic [7:0] LEN_INFO   = 8'd8;

    // TX scheduler states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_SRC   = 3'd2,
        ST_LEN   = 3'd3,
        ST_FETCH = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSUM  = 3'd6
    } tx_state_t;

    // Source tag byte carried in the SRC slot of a frame
    function automatic logic [7:0] src_tag(input logic [1:0] src);
        return SRC_TAG_BASE + {6'd0, src};
    endfunction

endpackage

// File: rtl/tx_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tx_priority_arbiter
//   Fixed-priority arbiter with anti-starvation aging. The winner is the
//   lowest-index pending source whose age has reached STARVE_LIMIT, or the
//   lowest-index pending source when none has. Ages update on grant_en.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset (ages -> 0)
//   req       pending request per source
//   grant_en  one-cycle strobe: the current winner is being granted
//   any_req   at least one source pending
//   winner    index of the source that would be granted this cycle
// ---------------------------------------------------------------------------
module tx_priority_arbiter
    import comms_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               grant_en,
    output logic               any_req,
    output logic [1:0]         winner
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age_q [NUM_SRC];

    logic       starved_found;
    logic [1:0] starved_idx;
    logic [1:0] normal_idx;

    // Scan from the highest index down so the lowest index wins last.
    always_comb begin
        starved_found = 1'b0;
        starved_idx   = 2'd0;
        normal_idx    = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                normal_idx = 2'(i);
                if (age_q[i] >= AGE_MAX) begin
                    starved_found = 1'b1;
                    starved_idx   = 2'(i);
                end
            end
        end
        winner  = starved_found ? starved_idx : normal_idx;
        any_req = |req;
    end

    // Granted source resets, skipped pending sources age (saturating),
    // idle sources forget any history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                age_q[i] <= '0;
            end
        end else if (grant_en) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (2'(i) == winner) begin
                    age_q[i] <= '0;
                end else if (req[i]) begin
                    age_q[i] <= (age_q[i] >= AGE_MAX) ? AGE_MAX : age_q[i] + AGE_W'(1);
                end else begin
                    age_q[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/comms_tx_scheduler.sv
// ---------------------------------------------------------------------------
// comms_tx_scheduler
//   Shares the serial TX byte channel between NUM_SRC frame sources. Each
//   granted source is sent as SYNC, SRC, LEN, payload..., XOR checksum.
//   Payload bytes are fetched through a shared read port with one cycle of
//   read latency.
//
// Handshake: a byte transfers on a cycle where tx_valid_out && tx_ready_in.
//   Once tx_valid_out rises it stays high and tx_byte_out stays stable until
//   that transfer cycle.
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   enable_in          allow new frames to start (sampled in IDLE only)
//   req_in, len_in     per-source level request and payload length
//   rd_src_out/addr    payload read port; rd_data_in valid one cycle later
//   tx_byte_out/valid  byte stream to the UART, tx_ready_in from the UART
//   grant_out          one-hot pulse when a source is granted
//   done_out           one-hot pulse after that source's checksum transfers
//   busy_out           high from grant until done
//   err_out            sticky: a granted length exceeded MAX_LEN
//   frame_cnt_out      completed frame counter (wraps)
//   state_out          current FSM state for observation
// ---------------------------------------------------------------------------
module comms_tx_scheduler
    import comms_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int MAX_LEN      = 63,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    input  logic [NUM_SRC-1:0]   req_in,
    input  logic [NUM_SRC*8-1:0] len_in,
    output logic [1:0]           rd_src_out,
    output logic [5:0]           rd_addr_out,
    input  logic [7:0]           rd_data_in,
    output logic [7:0]           tx_byte_out,
    output logic                 tx_valid_out,
    input  logic                 tx_ready_in,
    output logic [NUM_SRC-1:0]   grant_out,
    output logic [NUM_SRC-1:0]   done_out,
    output logic                 busy_out,
    output logic                 err_out,
    output logic [15:0]          frame_cnt_out,
    output tx_state_t            state_out
);

    tx_state_t   state_q;
    logic [1:0]  src_q;
    logic [5:0]  len_q;
    logic [5:0]  idx_q;
    logic [7:0]  csum_q;
    logic        data_loaded_q;
    logic [15:0] frame_cnt_q;

    logic        any_req;
    logic [1:0]  win;
    logic        start;
    logic        accept;
    logic [7:0]  win_len_raw;
    logic [5:0]  win_len;
    logic        win_len_over;

    assign accept        = tx_valid_out && tx_ready_in;
    assign start         = (state_q == ST_IDLE) && enable_in && any_req;
    assign frame_cnt_out = frame_cnt_q;
    assign state_out     = state_q;

    tx_priority_arbiter #(
        .NUM_SRC      (NUM_SRC),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk      (clk_in),
        .rst      (rst_in),
        .req      (req_in),
        .grant_en (start),
        .any_req  (any_req),
        .winner   (win)
    );

    // Winner's length, clamped to what one frame can carry.
    always_comb begin
        win_len_raw  = len_in[8*int'(win) +: 8];
        win_len_over = (win_len_raw > 8'(MAX_LEN));
        win_len      = win_len_over ? 6'(MAX_LEN) : win_len_raw[5:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            src_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            csum_q        <= '0;
            data_loaded_q <= 1'b0;
            frame_cnt_q   <= '0;
            rd_src_out    <= '0;
            rd_addr_out   <= '0;
            tx_byte_out   <= '0;
            tx_valid_out  <= 1'b0;
            grant_out     <= '0;
            done_out      <= '0;
            busy_out      <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            grant_out <= '0;
            done_out  <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        grant_out    <= NUM_SRC'(1) << win;
                        src_q        <= win;
                        len_q        <= win_len;
                        busy_out     <= 1'b1;
                        csum_q       <= '0;
                        tx_byte_out  <= SYNC_BYTE;
                        tx_valid_out <= 1'b1;
                        state_q      <= ST_SYNC;
                        if (win_len_over) begin
                            err_out <= 1'b1;
                        end
                    end
                end

                ST_SYNC: begin
                    // SYNC is not part of the checksum; it starts at the tag.
                    if (accept) begin
                        tx_byte_out <= src_tag(src_q);
                        csum_q      <= src_tag(src_q);
                        state_q     <= ST_SRC;
                    end
                end

                ST_SRC: begin
                    if (accept) begin
                        tx_byte_out <= {2'd0, len_q};
                        csum_q      <= csum_q ^ {2'd0, len_q};
                        state_q     <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (accept) begin
                        if (len_q != 6'd0) begin
                            tx_valid_out <= 1'b0;
                            idx_q        <= '0;
                            rd_addr_out  <= '0;
                            rd_src_out   <= src_q;
                            state_q      <= ST_FETCH;
                        end else begin
                            tx_byte_out <= csum_q;
                            state_q     <= ST_CSUM;
                        end
                    end
                end

                ST_FETCH: begin
                    // Address is on the read port this cycle; data arrives next.
                    data_loaded_q <= 1'b0;
                    state_q       <= ST_DATA;
                end

                ST_DATA: begin
                    if (!data_loaded_q) begin
                        tx_byte_out   <= rd_data_in;
                        csum_q        <= csum_q ^ rd_data_in;
                        tx_valid_out  <= 1'b1;
                        data_loaded_q <= 1'b1;
                    end else if (accept) begin
                        if (idx_q == len_q - 6'd1) begin
                            tx_byte_out <= csum_q;
                            state_q     <= ST_CSUM;
                        end else begin
                            idx_q        <= idx_q + 6'd1;
                            rd_addr_out  <= idx_q + 6'd1;
                            tx_valid_out <= 1'b0;
                            state_q      <= ST_FETCH;
                        end
                    end
                end

                ST_CSUM: begin
                    if (accept) begin
                        tx_valid_out <= 1'b0;
                        done_out     <= NUM_SRC'(1) << src_q;
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
                        busy_out     <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                default: begin
                    tx_valid_out <= 1'b0;
                    busy_out     <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comms_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_comms_tx_scheduler
//   Self-checking bench for comms_tx_scheduler. Expected frame bytes and
//   grant order are queued when a test sets up its requests and are popped
//   as the DUT grants and transfers bytes.
// ---------------------------------------------------------------------------
module tb_comms_tx_scheduler;
    import comms_pkg::*;

    localparam int NSRC = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              enable_in;
    logic [NSRC-1:0]   req_in;
    logic [NSRC*8-1:0] len_in;
    logic [1:0]        rd_src_out;
    logic [5:0]        rd_addr_out;
    logic [7:0]        rd_data_in = 8'd0;
    logic [7:0]        tx_byte_out;
    logic              tx_valid_out;
    logic              tx_ready_in;
    logic [NSRC-1:0]   grant_out;
    logic [NSRC-1:0]   done_out;
    logic              busy_out;
    logic              err_out;
    logic [15:0]       frame_cnt_out;
    tx_state_t         state_out;

    comms_tx_scheduler dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .enable_in     (enable_in),
        .req_in        (req_in),
        .len_in        (len_in),
        .rd_src_out    (rd_src_out),
        .rd_addr_out   (rd_addr_out),
        .rd_data_in    (rd_data_in),
        .tx_byte_out   (tx_byte_out),
        .tx_valid_out  (tx_valid_out),
        .tx_ready_in   (tx_ready_in),
        .grant_out     (grant_out),
        .done_out      (done_out),
        .busy_out      (busy_out),
        .err_out       (err_out),
        .frame_cnt_out (frame_cnt_out),
        .state_out     (state_out)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         exp_grant_q[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_frames = 0;
    int         cur_src = 0;
    bit         hold_req = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Payload content seen by the read port
    function automatic logic [7:0] payload(input int s, input int i);
        if (s == 1) return 8'((i + 1) * 17);
        return 8'((s * 64) ^ (i * 3) ^ 8'h5A);
    endfunction

    // Source-side memory: one cycle of read latency
    always @(posedge clk) rd_data_in <= payload(int'(rd_src_out), int'(rd_addr_out));

    // ---------------- driver tasks ----------------
    task automatic push_frame(input int s, input int len);
        int         l;
        logic [7:0] c;
        logic [7:0] p;
        l = (len > 63) ? 63 : len;
        len_in[s*8 +: 8] = 8'(len);
        exp_q.push_back(8'hA5);
        c = 8'(8'h10 + s);
        exp_q.push_back(c);
        exp_q.push_back(8'(l));
        c = c ^ 8'(l);
        for (int i = 0; i < l; i++) begin
            p = payload(s, i);
            exp_q.push_back(p);
            c = c ^ p;
        end
        exp_q.push_back(c);
        exp_grant_q.push_back(s);
        exp_frames++;
    endtask

    // Run until all queued frames are sent; sources drop requests on done.
    task automatic run_frames(input int budget, input bit rand_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_grant_q.size() != 0 || busy_out || req_in != '0)
               && n < budget) begin
            @(negedge clk);
            n++;
            if (hold_req) begin
                if (done_out != '0 && exp_grant_q.size() == 0) req_in = '0;
            end else begin
                req_in = req_in & ~done_out;
            end
            tx_ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        tx_ready_in = 1'b1;
        check("frames_timeout", 32'(n < budget), 32'd1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid_out), 32'd1);
                check("hold_byte", 32'(tx_byte_out), 32'(prev_byte));
            end
            if (tx_valid_out && tx_ready_in) begin
                if (exp_q.size() == 0) check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                else check("tx_byte", 32'(tx_byte_out), 32'(exp_q.pop_front()));
            end
            if (grant_out != '0) begin
                if (exp_grant_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant_out), 32'd0);
                end else begin
                    cur_src = exp_grant_q.pop_front();
                    check("grant", 32'(grant_out), 32'(1 << cur_src));
                end
            end
            if (done_out != '0) check("done", 32'(done_out), 32'(1 << cur_src));
            prev_stall = tx_valid_out && !tx_ready_in;
            prev_byte  = tx_byte_out;
        end
    end

    // ---------------- stimulus ----------------
    int order[16] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
    int n;

    initial begin
        rst         = 1'b1;
        enable_in   = 1'b1;
        req_in      = '0;
        len_in      = '0;
        tx_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(tx_valid_out), 32'd0);
        check("rst_byte", 32'(tx_byte_out), 32'd0);
        check("rst_grant", 32'(grant_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_cnt", 32'(frame_cnt_out), 32'd0);
        check("rst_addr", 32'(rd_addr_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame format: src1, len 3
        push_frame(1, int'(LEN_PLAYER));
        req_in = 3'b010;
        run_frames(200, 1'b0);
        check("cnt_format", 32'(frame_cnt_out), 32'(exp_frames));

        // Backpressure on the LEN byte
        push_frame(1, 3);
        req_in = 3'b010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx_valid_out && state_out == ST_LEN) && n < 100);
        check("reach_len", 32'(n < 100), 32'd1);
        tx_ready_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_byte", 32'(tx_byte_out), 32'h03);
            check("bp_valid", 32'(tx_valid_out), 32'd1);
            check("bp_addr", 32'(rd_addr_out), 32'd2);
        end
        tx_ready_in = 1'b1;
        run_frames(200, 1'b0);

        // Empty frame
        push_frame(2, 0);
        req_in = 3'b100;
        run_frames(100, 1'b0);

        // Oversize frame with random backpressure
        check("err_before", 32'(err_out), 32'd0);
        push_frame(0, 70);
        req_in = 3'b001;
        run_frames(3000, 1'b1);
        check("err_set", 32'(err_out), 32'd1);
        check("cnt_oversize", 32'(frame_cnt_out), 32'(exp_frames));

        // Enable low holds off grants
        enable_in = 1'b0;
        len_in[7:0] = 8'd5;
        req_in = 3'b001;
        repeat (20) @(negedge clk);
        check("disabled_busy", 32'(busy_out), 32'd0);
        push_frame(0, 5);
        enable_in = 1'b1;
        run_frames(300, 1'b0);
        check("err_sticky", 32'(err_out), 32'd1);

        // Starvation: all sources held requesting
        hold_req = 1'b1;
        foreach (order[i]) push_frame(order[i], (order[i] == 0) ? 1 : (order[i] == 1) ? 2 : 0);
        req_in = 3'b111;
        run_frames(3000, 1'b0);
        hold_req = 1'b0;
        check("cnt_starve", 32'(frame_cnt_out), 32'(exp_frames));

        // Reset during payload index 10
        push_frame(0, 20);
        req_in = 3'b001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(state_out == ST_DATA && rd_addr_out == 6'd10) && n < 300);
        check("reach_idx10", 32'(n < 300), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(tx_valid_out), 32'd0);
        check("mid_rst_byte", 32'(tx_byte_out), 32'd0);
        check("mid_rst_busy", 32'(busy_out), 32'd0);
        check("mid_rst_addr", 32'(rd_addr_out), 32'd0);
        check("mid_rst_src", 32'(rd_src_out), 32'd0);
        check("mid_rst_err", 32'(err_out), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt_out), 32'd0);
        check("mid_rst_state", 32'(state_out), 32'(ST_IDLE));
        exp_q.delete();
        exp_grant_q.delete();
        exp_frames = 0;
        req_in = 3'b100;
        push_frame(2, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frames(300, 1'b0);
        check("cnt_after_rst", 32'(frame_cnt_out), 32'(exp_frames));

        // Frame counter wrap
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        check("cnt_preload", 32'(frame_cnt_out), 32'hFFFF);
        push_frame(1, 1);
        req_in = 3'b010;
        run_frames(200, 1'b0);
        check("cnt_wrap", 32'(frame_cnt_out), 32'h0000);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
